// File: rtl/div_pkg.sv
// Shared constants and state type for the sequential divider.
package div_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 6;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(31);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial subtract of the divisor magnitude
// from the shifted partial remainder, restore on borrow.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = div_pkg::WIDTH
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_diff;
  logic           w_borrow;

  // i_rem < 2*i_div always holds, so the difference lies in (-div, div)
  // and its top bit is the borrow; either outcome fits back in WIDTH bits.
  assign w_diff   = i_rem - {1'b0, i_div};
  assign w_borrow = w_diff[WIDTH];
  assign o_qbit   = ~w_borrow;
  assign o_rem    = w_borrow ? i_rem[WIDTH-1:0] : w_diff[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// Iterative restoring divider, 32 iterations plus sign-fix and done cycles.
// Define DIV_SIGNED_EN for two's complement operands; default is unsigned.
module div_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = div_pkg::WIDTH,
  parameter int unsigned CNT_W = div_pkg::CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_b;
  logic             r_dz;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_rem_out;
  logic             r_exc;
  logic             r_rdy;
  logic             r_busy;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_rem_next;
  logic             w_qbit;

`ifdef DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;

  assign w_a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
`else
  assign w_a_mag = data_operandA;
  assign w_b_mag = data_operandB;
`endif

  // Dividend bits leave the top of Q and enter the bottom of R.
  assign w_shift = {r_r, r_q[WIDTH-1]};

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem  (w_shift),
    .i_div  (r_b),
    .o_rem  (w_rem_next),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_q       <= '0;
      r_r       <= '0;
      r_b       <= '0;
      r_dz      <= 1'b0;
      r_result  <= '0;
      r_rem_out <= '0;
      r_exc     <= 1'b0;
      r_rdy     <= 1'b0;
      r_busy    <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
`endif
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ctrl_DIV) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_r    <= '0;
            if (data_operandB == '0) begin
              r_dz    <= 1'b1;
              r_q     <= '0;
              r_state <= DONE;
            end else begin
              r_dz    <= 1'b0;
              r_q     <= w_a_mag;
              r_b     <= w_b_mag;
`ifdef DIV_SIGNED_EN
              r_neg_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
              r_neg_r <= data_operandA[WIDTH-1];
`endif
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_r   <= w_rem_next;
          r_q   <= {r_q[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_ITER) begin
            r_state <= FIX;
          end
        end
        FIX: begin
`ifdef DIV_SIGNED_EN
          if (r_neg_q) r_q <= -r_q;
          if (r_neg_r) r_r <= -r_r;
`endif
          r_state <= DONE;
        end
        DONE: begin
          r_result  <= r_q;
          r_rem_out <= r_r;
          r_exc     <= r_dz;
          r_rdy     <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_remainder = r_rem_out;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = r_busy;

endmodule
